// File: rtl/fetch_unit.sv
// fetch_unit: Thumb fetch stage. Reads 32-bit words from instruction
// memory (single outstanding req/ack) and splits them into halfwords that
// are buffered in a prefetch FIFO. One halfword per cycle goes to the
// decoder through the registered o_ir / o_pc_r / o_ir_valid outputs.
// Ports: clk, rst (sync, active-high); i_stall, i_branch, i_branch_target
// from the decoder; o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata to
// instruction memory; o_ir, o_ir_valid, o_pc_r to the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [15:0] o_ir,
  output logic        o_ir_valid,
  output logic [31:0] o_pc_r
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] TWO   = (AW+1)'(2);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] ZERO  = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [1:0]    state_br;
  logic [31:0]   fa;
  logic [31:0]   hpc;
  logic          skip;

  logic [15:0]   q [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] wp1;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW:0]   free;

  logic          ack_ok;
  logic          do_push;
  logic          ld;
  logic          do_pop;
  logic [AW:0]   n_push;
  logic [AW:0]   n_pop;

  assign o_imem_req  = (state == S_REQ);
  assign o_imem_addr = fa;
  assign free        = DEPTH - cnt;
  assign wp1         = wp + AW'(1);

  always_comb begin
    ack_ok  = (state == S_REQ) && i_imem_ack;
    do_push = ack_ok && !i_branch && !rst;
    n_push  = ZERO;
    if (do_push) n_push = skip ? ONE : TWO;
    ld      = !o_ir_valid || !i_stall;
    do_pop  = ld && (cnt != ZERO) && !i_branch;
    n_pop   = do_pop ? ONE : ZERO;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (free >= TWO) state_nx = S_REQ;
      S_REQ:  if (i_imem_ack) state_nx = S_IDLE;
      S_DROP: if (i_imem_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // On redirect an in-flight read must still be retired: without its ack
  // we park in DROP; an ack arriving in the branch cycle retires it now.
  always_comb begin
    state_br = S_IDLE;
    unique case (state)
      S_IDLE: state_br = S_IDLE;
      S_REQ:  state_br = i_imem_ack ? S_IDLE : S_DROP;
      S_DROP: state_br = i_imem_ack ? S_IDLE : S_DROP;
      default: state_br = S_IDLE;
    endcase
  end

  // A skipped lower half means the word starts mid-word after a branch.
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (skip) begin
        q[wp] <= i_imem_rdata[31:16];
      end else begin
        q[wp]  <= i_imem_rdata[15:0];
        q[wp1] <= i_imem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fa         <= RESET_PC & ~32'd3;
      skip       <= RESET_PC[1];
      hpc        <= RESET_PC & ~32'd1;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      o_ir       <= '0;
      o_ir_valid <= 1'b0;
      o_pc_r     <= RESET_PC & ~32'd1;
    end else if (i_branch) begin
      state      <= state_br;
      fa         <= i_branch_target & ~32'd3;
      skip       <= i_branch_target[1];
      hpc        <= i_branch_target & ~32'd1;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      o_ir_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (ack_ok) begin
        fa   <= fa + 32'd4;
        skip <= 1'b0;
      end
      wp  <= wp + n_push[AW-1:0];
      rp  <= rp + n_pop[AW-1:0];
      cnt <= cnt + n_push - n_pop;
      if (ld) begin
        if (cnt != ZERO) begin
          o_ir       <= q[rp];
          o_pc_r     <= hpc;
          hpc        <= hpc + 32'd2;
          o_ir_valid <= 1'b1;
        end else begin
          o_ir_valid <= 1'b0;
        end
      end
    end
  end

endmodule
